// File: rtl/des_pkg.sv
// Shared DES key-schedule definitions: FSM states, PC-2 table, shift schedule
// and the 28-bit half-key rotation helpers.
package des_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam int NUM_ROUNDS = 16;

   // PC-2 selection, entry j gives the 1-based CD bit that feeds output bit j+1.
   localparam int PC2_TABLE [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
   };

   // Left-rotation applied before each encrypt round; sums to 28.
   localparam int SHIFT_SCHED [16] = '{
      1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1
   };

   // Rotate a 28-bit half key left by n (1 or 2).
   function automatic logic [27:0] rotl28(input logic [27:0] x, input int n);
      return (x << n) | (x >> (28 - n));
   endfunction

   // Rotate a 28-bit half key right by n (1 or 2).
   function automatic logic [27:0] rotr28(input logic [27:0] x, input int n);
      return (x >> n) | (x << (28 - n));
   endfunction

endpackage

// File: rtl/des_pc2.sv
// Combinational PC-2 permutation: 56-bit rotated C,D in, 48-bit round subkey out.
// Bit 55 of cd_i is DES bit 1; bit 47 of subkey_o is PC-2 output bit 1.
module des_pc2
   import des_pkg::*;
(
   input  logic [55:0] cd_i,
   output logic [47:0] subkey_o
);

   genvar gi;
   generate
      for (gi = 0; gi < 48; gi++) begin : g_pc2
         localparam int SRC_IDX = 56 - PC2_TABLE[gi];
         assign subkey_o[47 - gi] = cd_i[SRC_IDX];
      end
   endgenerate

endmodule

// File: rtl/des_key_sched.sv
// DES key schedule: streams the 16 round subkeys for one key over a
// valid/ready handshake, in encrypt (K1..K16) or decrypt (K16..K1) order.
module des_key_sched
   import des_pkg::*;
#(
   parameter int ROUNDS = 16
)(
   input  logic        clk,
   input  logic        rst,
   input  logic [55:0] key_in,
   input  logic        decrypt,
   input  logic        start,
   output logic        ready,
   output logic [47:0] subkey,
   output logic        subkey_valid,
   input  logic        subkey_ready,
   output logic [3:0]  round,
   output logic        done
);

   generate
      if (ROUNDS != NUM_ROUNDS) begin : g_bad_rounds
         $error("des_key_sched: ROUNDS must be 16");
      end
   endgenerate

   localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);

   state_t      state_q, state_d;
   logic [27:0] c_q, c_d;
   logic [27:0] d_q, d_d;
   logic        mode_q, mode_d;
   logic [3:0]  round_q, round_d;
   logic [47:0] pc2_subkey;
   logic        xfer;

   assign xfer = (state_q == S_RUN) && subkey_ready;

   // Next-state logic: load the rotated key on start, advance one round per transfer.
   always_comb begin
      state_d = state_q;
      c_d     = c_q;
      d_d     = d_q;
      mode_d  = mode_q;
      round_d = round_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RUN;
               mode_d  = decrypt;
               round_d = 4'd0;
               // Decrypt starts at K16, whose cumulative rotation is a full 28 (identity).
               if (decrypt) begin
                  c_d = key_in[55:28];
                  d_d = key_in[27:0];
               end else begin
                  c_d = rotl28(key_in[55:28], SHIFT_SCHED[0]);
                  d_d = rotl28(key_in[27:0], SHIFT_SCHED[0]);
               end
            end
         end
         S_RUN: begin
            if (xfer) begin
               if (round_q == LAST_ROUND) begin
                  state_d = S_DONE;
                  round_d = 4'd0;
               end else begin
                  round_d = round_q + 4'd1;
                  // Decrypt undoes the encrypt shifts from the end of the schedule backwards.
                  if (mode_q) begin
                     c_d = rotr28(c_q, SHIFT_SCHED[4'd15 - round_q]);
                     d_d = rotr28(d_q, SHIFT_SCHED[4'd15 - round_q]);
                  end else begin
                     c_d = rotl28(c_q, SHIFT_SCHED[round_q + 4'd1]);
                     d_d = rotl28(d_q, SHIFT_SCHED[round_q + 4'd1]);
                  end
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         c_q     <= '0;
         d_q     <= '0;
         mode_q  <= 1'b0;
         round_q <= '0;
      end else begin
         state_q <= state_d;
         c_q     <= c_d;
         d_q     <= d_d;
         mode_q  <= mode_d;
         round_q <= round_d;
      end
   end

   des_pc2 u_pc2 (
      .cd_i     ({c_q, d_q}),
      .subkey_o (pc2_subkey)
   );

   assign ready        = (state_q == S_IDLE);
   assign subkey_valid = (state_q == S_RUN);
   assign done         = (state_q == S_DONE);
   // Outputs read zero whenever no subkey is being presented.
   assign subkey       = subkey_valid ? pc2_subkey : 48'd0;
   assign round        = subkey_valid ? round_q : 4'd0;

endmodule

// File: doc/des_key_sched.md
DES_KEY_SCHED -- requirements
Module: des_key_sched

Interface
REQ-001 SHALL have parameter ROUNDS, default 16, number of subkeys per run; 16 is the only legal value and other values SHALL fail elaboration.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port key_in  input  56  post-PC-1 key, C = key_in[55:28], D = key_in[27:0], with key_in[55] as DES bit 1; driven by the upstream trojan_seq payload.
REQ-005 SHALL have port decrypt  input  1  0 = encrypt order K1..K16, 1 = decrypt order K16..K1; sampled with start.
REQ-006 SHALL have port start  input  1  run request, accepted only when ready=1.
REQ-007 SHALL have port ready  output  1  1 in IDLE only.
REQ-008 SHALL have port subkey  output  48  PC-2 round subkey, where subkey[47] is PC-2 output bit 1.
REQ-009 SHALL have port subkey_valid  output  1  subkey is valid this cycle.
REQ-010 SHALL have port subkey_ready  input  1  consumer accepts subkey; a transfer occurs on valid & ready.
REQ-011 SHALL have port round  output  4  index of the presented subkey, 0..15, counting transfers.
REQ-012 SHALL have port done  output  1  one-cycle pulse in the cycle after the 16th transfer.

Function
REQ-013 SHALL use states IDLE, RUN and DONE.
REQ-014 SHALL make transitions as follows:
- IDLE->RUN on start.
- RUN->DONE on the 16th transfer.
- DONE->IDLE unconditionally.
REQ-015 SHALL, on start acceptance in cycle N, latch key_in and decrypt and present the first subkey with subkey_valid=1 in cycle N+1 (latency 1).
REQ-016 SHALL ignore key_in and decrypt changes after acceptance until the next acceptance; upstream negedge payload updates SHALL NOT affect a run in progress.
REQ-017 SHALL hold subkey and round stable while subkey_valid=1 and subkey_ready=0, with no skipping and no duplication.
REQ-018 SHALL, in encrypt mode, compute round i from C,D rotated left by cumulative shifts 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 (total 28).
REQ-019 SHALL, in decrypt mode, compute round 0 from unrotated C,D and each later round by a further right-rotation of 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 applied in order.
REQ-020 SHALL rotate C and D independently, each modulo 28 bits; no bit SHALL cross between C and D.
REQ-021 SHALL advance the rotation register only on a transfer; subkey SHALL be a combinational PC-2 of the registered C,D.
REQ-022 SHALL ignore start while in RUN or DONE; ready=0 in those states.
REQ-023 SHALL allow a start in the IDLE cycle immediately after DONE, giving back-to-back runs 1 idle cycle apart.
REQ-024 SHALL keep subkey_valid=0 and done=0 in IDLE; subkey and round SHALL then read 0.
REQ-025 SHALL allow subkey_ready=1 with subkey_valid=0; this SHALL have no effect.

Reset
REQ-026 SHALL, on rst assertion, immediately (asynchronously) force state=IDLE, ready=1, subkey_valid=0, done=0, round=0, subkey=0 and the latched key and mode to 0.
REQ-027 SHALL, on rst mid-run, abandon the run with no done pulse; the first start after deassertion SHALL begin a fresh run.
REQ-028 SHALL drive no output X after reset.

Structure
REQ-029 SHALL place the PC-2 table, the 16-entry shift schedule and the state enum in shared package des_pkg.
REQ-030 SHALL put the PC-2 permutation in combinational sub-module des_pc2, mapping 56 bits in to 48 bits out.
REQ-031 SHALL keep the counter, rotation registers and FSM in des_key_sched.

Verification
REQ-032 SHALL cover: key_in=56'hF0CCAAF556678F, decrypt=0, subkey_ready=1 -> round 0 subkey=48'h1B02EFFC7072, round 15 subkey=48'hCB3D8B0E17F5, done in the 17th cycle after acceptance.
REQ-033 SHALL cover: the same key with decrypt=1 -> round 0 subkey=48'hCB3D8B0E17F5, round 15 subkey=48'h1B02EFFC7072.
REQ-034 SHALL cover: subkey_ready toggled randomly, 50% -> exactly 16 transfers in round order 0..15, values matching the REQ-032 model, subkey stable on every stall cycle.
REQ-035 SHALL cover: key_in LSB flipped (trojan payload) one cycle after acceptance -> all 16 subkeys identical to the unflipped run; a new run started after the flip matches the model for key 56'hF0CCAAF556678E.
REQ-036 SHALL cover: rst pulsed at round 7 -> subkey_valid=0 and ready=1 before the next posedge, no done pulse; a restart reproduces the REQ-032 sequence.
REQ-037 SHALL cover: start held high continuously -> runs separated by exactly one IDLE cycle; start while busy leaves the run unchanged.
